// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-bus load/store unit: byte lanes, store replication, load extension, ack timeout
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being force-aligned.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    lane;
  logic [2:0]    f3_q;

  logic          is_byte, is_half, misalign, trap, timeout;
  logic [1:0]    a_lo;
  logic [3:0]    be_d;
  logic [31:0]   wd_d, ext;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  // Funct3[1:0] picks the size; 011/110/111 fall through to word.
  always_comb begin
    is_byte  = (Funct3[1:0] == 2'b00);
    is_half  = (Funct3[1:0] == 2'b01);
    misalign = is_half ? ALUResult[0] : (!is_byte && (ALUResult[1:0] != 2'b00));
    a_lo     = is_byte ? ALUResult[1:0] : (is_half ? {ALUResult[1], 1'b0} : 2'b00);
    be_d     = is_byte ? (4'b0001 << a_lo) : (is_half ? (4'b0011 << a_lo) : 4'b1111);
    wd_d     = is_byte ? {4{WriteData[7:0]}} : (is_half ? {2{WriteData[15:0]}} : WriteData);
  end

`ifdef MISALIGN_TRAP_EN
  assign trap = misalign;
`else
  assign trap = 1'b0;
`endif

  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  always_comb begin
    byte_sel = bus_rdata[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  ext = {24'h0, byte_sel};
      3'b101:  ext = {16'h0, half_sel};
      default: ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    Stall     = 1'b0;
    bus_req   = 1'b0;
    case (state)
      IDLE: if (MemRead || MemWrite) begin
        Stall     = 1'b1;
        state_nxt = trap ? DONE : REQ;
      end
      REQ: begin
        Stall   = 1'b1;
        bus_req = 1'b1;
        if (bus_ack || timeout) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ReadData  <= '0;
      Fault     <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      lane      <= '0;
      f3_q      <= '0;
    end else begin
      state <= state_nxt;
      Fault <= 1'b0;
      case (state)
        IDLE: if (MemRead || MemWrite) begin
          bus_we    <= MemWrite;
          bus_addr  <= {ALUResult[31:2], 2'b00};
          bus_be    <= be_d;
          bus_wdata <= wd_d;
          lane      <= a_lo;
          f3_q      <= Funct3;
          cnt       <= '0;
          if (trap) Fault <= 1'b1;
        end
        // Ack has priority over a timeout landing in the same cycle.
        REQ: if (bus_ack) begin
          if (!bus_we) ReadData <= ext;
        end else if (timeout) begin
          Fault <= 1'b1;
          if (!bus_we) ReadData <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData, ReadData;
  logic        Stall, Fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ack;

  int tests = 0;
  int fails = 0;

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
    .Fault(Fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          ackd;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_rd;
    int          e_stall;
    logic        e_fault;
  } vec_t;

  vec_t vec [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int stalls;
    int k;
    @(negedge clk);
    MemRead = v.mr; MemWrite = v.mw; Funct3 = v.f3; ALUResult = v.a; WriteData = v.wd;
    stalls = 0;
    #1 if (Stall) stalls++;
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    k = 0;
    while (bus_req && k < 50) begin
      if (Stall) stalls++;
      if (k == 0) begin
        check($sformatf("v%0d addr", i), bus_addr, v.e_addr);
        check($sformatf("v%0d be", i), {28'h0, bus_be}, {28'h0, v.e_be});
        check($sformatf("v%0d wdata", i), bus_wdata, v.e_wdata);
        check($sformatf("v%0d we", i), {31'h0, bus_we}, {31'h0, v.e_we});
      end
      if (k == v.ackd) begin
        bus_ack = 1'b1;
        bus_rdata = v.rdata;
      end
      @(negedge clk);
      bus_ack = 1'b0;
      k++;
    end
    check($sformatf("v%0d stall_cycles", i), stalls, v.e_stall);
    check($sformatf("v%0d stall_done", i), {31'h0, Stall}, 32'h0);
    check($sformatf("v%0d readdata", i), ReadData, v.e_rd);
    check($sformatf("v%0d fault", i), {31'h0, Fault}, {31'h0, v.e_fault});
    @(negedge clk);
    check($sformatf("v%0d fault_pulse_end", i), {31'h0, Fault}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //               mr mw f3      a           wd            rdata        ackd e_addr      e_wdata       be     we e_rd          stall fault
    vec[0]  = '{1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0,  32'h100, 32'h0,        4'hF, 0, 32'hDEADBEEF, 2, 0};
    vec[1]  = '{1, 0, 3'b000, 32'h103, 32'h0,        32'h80123456, 0,  32'h100, 32'h0,        4'h8, 0, 32'hFFFFFF80, 2, 0};
    vec[2]  = '{1, 0, 3'b100, 32'h103, 32'h0,        32'h80123456, 0,  32'h100, 32'h0,        4'h8, 0, 32'h00000080, 2, 0};
    vec[3]  = '{0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        4,  32'h200, 32'hABCDABCD, 4'hC, 1, 32'h00000080, 6, 0};
    vec[4]  = '{1, 0, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 0,  32'h100, 32'h0,        4'hC, 0, 32'hFFFF8001, 2, 0};
    vec[5]  = '{1, 0, 3'b101, 32'h100, 32'h0,        32'h80017FFF, 0,  32'h100, 32'h0,        4'h3, 0, 32'h00007FFF, 2, 0};
    vec[6]  = '{0, 1, 3'b000, 32'h301, 32'h000000A5, 32'h0,        1,  32'h300, 32'hA5A5A5A5, 4'h2, 1, 32'h00007FFF, 3, 0};
`ifdef MISALIGN_TRAP_EN
    vec[7]  = '{0, 1, 3'b010, 32'h101, 32'hCAFEF00D, 32'h0,        0,  32'h100, 32'hCAFEF00D, 4'hF, 1, 32'h00007FFF, 1, 1};
`else
    vec[7]  = '{0, 1, 3'b010, 32'h101, 32'hCAFEF00D, 32'h0,        0,  32'h100, 32'hCAFEF00D, 4'hF, 1, 32'h00007FFF, 2, 0};
`endif
    vec[8]  = '{1, 1, 3'b010, 32'h040, 32'h11223344, 32'h0,        0,  32'h040, 32'h11223344, 4'hF, 1, 32'h00007FFF, 2, 0};
    vec[9]  = '{1, 0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 2,  32'h100, 32'h0,        4'h2, 0, 32'h0000007F, 4, 0};
    vec[10] = '{1, 0, 3'b011, 32'h044, 32'h0,        32'h55AA55AA, 0,  32'h044, 32'h0,        4'hF, 0, 32'h55AA55AA, 2, 0};
    vec[11] = '{1, 0, 3'b010, 32'h048, 32'h0,        32'h12345678, 7,  32'h048, 32'h0,        4'hF, 0, 32'h12345678, 9, 0};
    vec[12] = '{1, 0, 3'b010, 32'h04C, 32'h0,        32'h0,        99, 32'h04C, 32'h0,        4'hF, 0, 32'h00000000, 9, 1};
    vec[13] = '{1, 0, 3'b100, 32'h102, 32'h0,        32'hABCDEF01, 0,  32'h100, 32'h0,        4'h4, 0, 32'h000000CD, 2, 0};

    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b0;
    ALUResult = '0; WriteData = '0; bus_rdata = '0; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst bus_req", {31'h0, bus_req}, 32'h0);
    check("rst readdata", ReadData, 32'h0);
    check("rst fault", {31'h0, Fault}, 32'h0);
    check("rst stall", {31'h0, Stall}, 32'h0);
    check("rst bus_be", {28'h0, bus_be}, 32'h0);
    check("rst bus_addr", bus_addr, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(i, vec[i]);

    // stray ack while idle must not touch ReadData
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    check("idle_ack readdata", ReadData, 32'h000000CD);
    check("idle_ack bus_req", {31'h0, bus_req}, 32'h0);

    // reset in the middle of a request, then a late ack
    MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h10;
    @(negedge clk);
    MemRead = 1'b0;
    check("midrst req_before", {31'h0, bus_req}, 32'h1);
    reset = 1'b0;
    @(negedge clk);
    check("midrst bus_req", {31'h0, bus_req}, 32'h0);
    check("midrst stall", {31'h0, Stall}, 32'h0);
    check("midrst readdata", ReadData, 32'h0);
    reset = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus_ack = 1'b0;
    @(negedge clk);
    check("late_ack readdata", ReadData, 32'h0);
    check("late_ack bus_req", {31'h0, bus_req}, 32'h0);
    check("late_ack stall", {31'h0, Stall}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
